// File: rtl/avalon_timer_multi.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters with
// snapshot, sticky timeout, per-channel irq/tick vectors and a combined irq.
module avalon_timer_multi #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  parameter int          CH_AW        = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [CH_AW+1:0]  address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tick_out
);

  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);

  // Bus handshake: a write is accepted on every clk where chipselect & !write_n
  // (no waitrequest); readdata always reflects the address of the previous clk.
  logic             wr;
  logic [CH_AW-1:0] sel_ch;
  logic [1:0]       sel_reg;
  logic [31:0]      rd_next;

  assign wr      = chipselect & ~write_n;
  assign sel_ch  = address[CH_AW+1:2];
  assign sel_reg = address[1:0];

  logic [31:0] rd_status  [NUM_CH];
  logic [31:0] rd_control [NUM_CH];
  logic [31:0] rd_period  [NUM_CH];
  logic [31:0] rd_snap    [NUM_CH];

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:16], writedata[7:4]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             hit;
    logic             wr_status, wr_ctrl, wr_period, wr_snap, start, stop;
    logic [CNT_W-1:0] counter_q, period_q, snap_q;
    logic [7:0]       presc_q, pcnt_q;
    logic             run_q, to_q, ito_q, cont_q, tick_q;
    logic             tick, timeout;

    assign hit       = wr && (sel_ch == CH_AW'(g));
    assign wr_status = hit && (sel_reg == 2'd0);
    assign wr_ctrl   = hit && (sel_reg == 2'd1);
    assign wr_period = hit && (sel_reg == 2'd2);
    assign wr_snap   = hit && (sel_reg == 2'd3);
    assign start     = wr_ctrl & writedata[2];
    assign stop      = wr_ctrl & writedata[3];

    assign tick    = run_q && (pcnt_q == presc_q);
    assign timeout = tick && (counter_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        counter_q <= RST_PER;
        period_q  <= RST_PER;
        snap_q    <= '0;
        presc_q   <= '0;
        pcnt_q    <= '0;
        run_q     <= 1'b0;
        to_q      <= 1'b0;
        ito_q     <= 1'b0;
        cont_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        tick_q <= timeout;

        // A timeout on the same clk as a STATUS write must not be lost.
        if (wr_status) to_q <= 1'b0;
        if (timeout)   to_q <= 1'b1;

        if (tick)       pcnt_q <= '0;
        else if (run_q) pcnt_q <= pcnt_q + 8'd1;

        if (tick) counter_q <= timeout ? period_q : counter_q - 1'b1;
        if (timeout && !cont_q) run_q <= 1'b0;

        if (wr_ctrl) begin
          ito_q   <= writedata[0];
          cont_q  <= writedata[1];
          presc_q <= writedata[15:8];
          if (start) begin
            run_q  <= 1'b1;
            pcnt_q <= '0;
          end else if (stop) begin
            run_q <= 1'b0;
          end
        end

        if (wr_snap) snap_q <= counter_q;

        // Period write stops the channel and force-reloads, overriding any tick.
        if (wr_period) begin
          period_q  <= writedata[CNT_W-1:0];
          counter_q <= writedata[CNT_W-1:0];
          run_q     <= 1'b0;
          pcnt_q    <= '0;
        end
      end
    end

    assign rd_status[g]  = {30'b0, run_q, to_q};
    assign rd_control[g] = {16'b0, presc_q, 6'b0, cont_q, ito_q};
    assign rd_period[g]  = 32'(period_q);
    assign rd_snap[g]    = 32'(snap_q);
    assign irq_vec[g]    = to_q & ito_q;
    assign tick_out[g]   = tick_q;
  end

  // Unimplemented channel indices fall through and read as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == CH_AW'(i)) begin
        case (sel_reg)
          2'd0: rd_next = rd_status[i];
          2'd1: rd_next = rd_control[i];
          2'd2: rd_next = rd_period[i];
          2'd3: rd_next = rd_snap[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_avalon_timer_multi.sv
// Directed bench for avalon_timer_multi: register table plus timing sequences,
// with a 3-channel 16-bit instance sharing the bus for unimplemented-channel checks.
module tb_avalon_timer_multi;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [3:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;
  logic [3:0]  tick_out;
  logic [31:0] readdata3;
  logic        irq3;
  logic [2:0]  irq_vec3;
  logic [2:0]  tick_out3;

  int total = 0;
  int bad   = 0;

  avalon_timer_multi #(.NUM_CH(4), .CNT_W(32), .RESET_PERIOD(49999), .CH_AW(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .irq_vec(irq_vec), .tick_out(tick_out)
  );

  avalon_timer_multi #(.NUM_CH(3), .CNT_W(16), .RESET_PERIOD(49999), .CH_AW(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata3), .irq(irq3),
    .irq_vec(irq_vec3), .tick_out(tick_out3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  addr;
    logic        is_wr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic [31:0] d3);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d  = readdata;
    d3 = readdata3;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_out[ch] && n < limit);
    if (!tick_out[ch]) begin
      total++;
      bad++;
      $display("FAIL wait_tick ch%0d: no tick_out within %0d clk", ch, limit);
    end
  endtask

  logic [31:0] rd, rd3;
  int          n;
  int          pulses;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: reset state
    check("rst readdata", readdata, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst irq_vec", {28'd0, irq_vec}, 32'd0);
    check("rst tick_out", {28'd0, tick_out}, 32'd0);

    for (int c = 0; c < 4; c++) begin
      vecs.push_back('{4'(c * 4 + 0), 1'b0, 32'd0});
      vecs.push_back('{4'(c * 4 + 1), 1'b0, 32'd0});
      vecs.push_back('{4'(c * 4 + 2), 1'b0, 32'd49999});
      vecs.push_back('{4'(c * 4 + 3), 1'b0, 32'd0});
    end
    vecs.push_back('{4'd3,  1'b1, 32'd0});
    vecs.push_back('{4'd3,  1'b0, 32'd49999});
    vecs.push_back('{4'd13, 1'b1, 32'hFFFF_AB03});
    vecs.push_back('{4'd13, 1'b0, 32'h0000_AB03});
    vecs.push_back('{4'd14, 1'b1, 32'h1234_5678});
    vecs.push_back('{4'd14, 1'b0, 32'h1234_5678});
    vecs.push_back('{4'd12, 1'b0, 32'd0});

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd, rd3);
        check($sformatf("vec%0d read addr %0d", i, vecs[i].addr), rd, vecs[i].data);
      end
    end

    // T2: ch0 period 9, continuous, irq enabled
    bus_write(4'd2, 32'd9);
    bus_write(4'd1, 32'h0000_0007);
    wait_tick(0, 40, n);
    check("t2 first timeout latency", 32'(n), 32'd10);
    check("t2 irq_vec0 set", {31'd0, irq_vec[0]}, 32'd1);
    check("t2 irq set", {31'd0, irq}, 32'd1);
    wait_tick(0, 40, n);
    check("t2 timeout interval", 32'(n), 32'd10);
    bus_write(4'd0, 32'd0);
    check("t2 irq_vec0 cleared", {31'd0, irq_vec[0]}, 32'd0);
    check("t2 irq cleared", {31'd0, irq}, 32'd0);
    bus_write(4'd1, 32'h0000_0008);

    // T3: ch1 one-shot, period 4, prescale 3
    bus_write(4'd6, 32'd4);
    bus_write(4'd5, 32'h0000_0304);
    wait_tick(1, 60, n);
    check("t3 one-shot latency", 32'(n), 32'd20);
    bus_read(4'd4, rd, rd3);
    check("t3 status run=0 to=1", rd, 32'd1);
    check("t3 irq_vec1 masked", {31'd0, irq_vec[1]}, 32'd0);
    bus_write(4'd7, 32'd0);
    bus_read(4'd7, rd, rd3);
    check("t3 counter reloaded", rd, 32'd4);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick_out[1]) pulses++;
    end
    check("t3 no further timeouts", 32'(pulses), 32'd0);

    // T4: ch2 snapshot and STATUS write colliding with a timeout
    bus_write(4'd10, 32'd7);
    bus_write(4'd9, 32'h0000_0007);
    wait_tick(2, 40, n);
    check("t4 first timeout latency", 32'(n), 32'd8);
    bus_write(4'd11, 32'd0);
    bus_read(4'd11, rd, rd3);
    check("t4 snapshot value", rd, 32'd6);
    wait_tick(2, 40, n);
    bus_write(4'd8, 32'd0);
    check("t4 to cleared", {31'd0, irq_vec[2]}, 32'd0);
    repeat (4) @(negedge clk);
    bus_write(4'd8, 32'd0);
    check("t4 timeout on write clk", {31'd0, tick_out[2]}, 32'd1);
    bus_read(4'd8, rd, rd3);
    check("t4 status run=1 to=1", rd, 32'd3);
    check("t4 irq_vec2 kept", {31'd0, irq_vec[2]}, 32'd1);
    bus_write(4'd9, 32'h0000_0008);

    // T5: ch3 START|STOP then PERIOD write while running
    bus_write(4'd13, 32'h0000_000C);
    bus_read(4'd12, rd, rd3);
    check("t5 start wins", rd, 32'd2);
    bus_write(4'd14, 32'd5);
    bus_read(4'd12, rd, rd3);
    check("t5 period write stops", rd, 32'd0);
    bus_write(4'd15, 32'd0);
    bus_read(4'd15, rd, rd3);
    check("t5 counter = new period", rd, 32'd5);

    // T6: unimplemented channel on the 3-channel instance
    bus_read(4'd14, rd, rd3);
    check("t6 ch3 period main", rd, 32'd5);
    check("t6 ch3 period absent", rd3, 32'd0);
    bus_read(4'd13, rd, rd3);
    check("t6 ch3 control absent", rd3, 32'd0);
    bus_read(4'd10, rd, rd3);
    check("t6 ch2 period 16-bit", rd3, 32'd7);

    // reset asserted mid-count
    bus_write(4'd2, 32'd3);
    bus_write(4'd1, 32'h0000_0007);
    bus_read(4'd2, rd, rd3);
    check("rst2 period before", rd, 32'd3);
    wait_tick(0, 20, n);
    check("rst2 irq before", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst2 irq async", {31'd0, irq}, 32'd0);
    check("rst2 tick_out async", {28'd0, tick_out}, 32'd0);
    check("rst2 readdata async", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(4'd0, rd, rd3);
    check("rst2 status", rd, 32'd0);
    bus_read(4'd2, rd, rd3);
    check("rst2 period", rd, 32'd49999);
    check("rst2 period dut3", rd3, 32'd49999);
    bus_write(4'd3, 32'd0);
    bus_read(4'd3, rd, rd3);
    check("rst2 counter", rd, 32'd49999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
